prbs11_slos_tx: RTL and testbench
=================================

Name: prbs11_slos_tx

Overview:
Serial generator for SLOS1/SLOS2 ordered sets in the USB4 logical-layer lane-training path.
- Each SLOS is one full 2047-bit period of PRBS11, polynomial x^11+x^9+1.
- SLOS2 is the bitwise inverse of SLOS1.
- Sends a programmed number of back-to-back SLOS (or runs continuously), then reports completion.
- Drives the lane bit stream toward the SLOS checker at the far end.

Parameters:
SEED, 11'h400, LFSR load value at the start of every SLOS.
SLOS_LEN, 2047, bits per SLOS (must equal the PRBS11 period).
CNT_W, 8, width of repetition count and sent counter.

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset
start  input  1  request a burst; sampled only in IDLE
slos_sel  input  1  0 = SLOS1, 1 = SLOS2; latched at start
rep_count  input  CNT_W  number of SLOS to send; 0 = continuous; latched at start
stop  input  1  graceful stop: finish current SLOS, then complete
abort  input  1  immediate termination
data_out  output  1  serial bit, registered
tx_valid  output  1  data_out carries a SLOS bit this cycle
busy  output  1  high in SEND and DONE
slos_sent  output  1  one-cycle pulse coincident with last bit of each SLOS
done  output  1  one-cycle pulse after last bit of burst (graceful end only)
sent_count  output  CNT_W  SLOS completed in current/last burst; saturates at all-ones

Behaviour:
- Reset (async, reset=0):
  - state=IDLE, lfsr=SEED, bit_cnt=0, sel_q=0, rep_q=0, stop_pend=0.
  - All outputs 0; sent_count=0.
- Clock enable: none; all registers update every clk.
- LFSR next state: {lfsr[9:0], lfsr[10]^lfsr[8]}. Emitted bit = lfsr[0]^sel_q, taken before the shift.
- IDLE:
  - tx_valid=0, data_out=0.
  - On start=1 (and abort=0): latch sel_q<=slos_sel, rep_q<=rep_count; lfsr<=SEED, bit_cnt<=0, sent_count<=0, stop_pend<=0; go SEND.
- SEND, every cycle:
  - data_out<=lfsr[0]^sel_q, tx_valid<=1, lfsr<=next, bit_cnt<=bit_cnt+1.
  - First bit appears one cycle after the cycle in which start is sampled.
- Last bit of a SLOS (bit_cnt==SLOS_LEN-1):
  - slos_sent<=1 with that bit; bit_cnt<=0; lfsr<=SEED (forced, even though next() already returns SEED); sent_count<=sent_count+1, saturating.
  - Burst ends if stop_pend, or stop this cycle, or (rep_q!=0 and sent_count+1==rep_q): go DONE.
  - Otherwise the next SLOS starts the following cycle with no gap.
- stop asserted mid-SLOS sets stop_pend. The current SLOS always completes; a SLOS is never truncated by stop.
- DONE (one cycle): tx_valid=0, done=1, busy=1; then IDLE. start is ignored in DONE.
- abort (any state, priority over all else):
  - Next cycle: IDLE, tx_valid=0, slos_sent=0, done=0; lfsr=SEED, bit_cnt=0.
  - sent_count holds its value.
  - start in the same cycle as abort is ignored.
- Inputs slos_sel and rep_count are ignored outside start acceptance; changing them mid-burst has no effect.
- rep_count=0: continuous until stop or abort.
- Back-to-back burst: start is accepted on the IDLE cycle right after DONE. This gives a two-cycle tx_valid gap between bursts.

Decomposition:
- Shared package usb4_slos_pkg:
  - PRBS11_SEED = 11'h400, PRBS11_LEN = 2047, PRBS11 tap positions (10, 8).
  - State enum {IDLE, SEND, DONE}; SLOS1/SLOS2 select encoding.
  - The SLOS checker uses the same constants.
- One natural sub-module: prbs11_lfsr (load, advance, state out). Also reusable by the checker.

Test Plan:
- Reset mid-SEND (reset=0 for 1 cycle at bit 500) -> all outputs 0 immediately; state IDLE; after release, start gives a fresh SLOS from bit 0.
- start, slos_sel=0, rep_count=1 -> first 11 bits 0,1,0,0,0,0,0,0,0,0,1; 2047 tx_valid bits matching the golden x^11+x^9+1 model; slos_sent on bit 2047; done the next cycle; sent_count=1.
- slos_sel=1, rep_count=3 -> first 11 bits 1,0,1,1,1,1,1,1,1,1,0; 6141 contiguous valid bits; slos_sent at bits 2047/4094/6141; done once; sent_count=3.
- rep_count=0, stop pulsed at bit 3000 -> transmission continues to bit 4094; slos_sent twice; done; sent_count=2.
- abort at bit 100 of the second SLOS (rep_count=5) -> tx_valid=0 next cycle; no done; sent_count holds 1; a new start restarts at SEED.
- start held high through DONE -> new burst accepted on the IDLE cycle; exactly two-cycle tx_valid gap; second burst bit-identical to the first.

Source files
------------

// File: rtl/usb4_slos_pkg.sv
// Shared SLOS constants, state encoding and PRBS11 step function.
// The far-end SLOS checker uses the same definitions.
package usb4_slos_pkg;

   localparam logic [10:0] PRBS11_SEED   = 11'h400;
   localparam int          PRBS11_LEN    = 2047;
   localparam int          PRBS11_TAP_HI = 10;
   localparam int          PRBS11_TAP_LO = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      DONE = 2'd2
   } slos_state_t;

   typedef enum logic {
      SLOS1 = 1'b0,
      SLOS2 = 1'b1
   } slos_sel_t;

   // x^11 + x^9 + 1, shifting toward the MSB with feedback into bit 0
   function automatic logic [10:0] prbs11_next(input logic [10:0] s);
      return {s[9:0], s[PRBS11_TAP_HI] ^ s[PRBS11_TAP_LO]};
   endfunction

endpackage

// File: rtl/prbs11_slos_tx_if.sv
// Control/status bundle between a lane-training sequencer and the SLOS generator.
interface prbs11_slos_tx_if #(
   parameter int CNT_W = 8
);
   logic             start;
   logic             slos_sel;
   logic [CNT_W-1:0] rep_count;
   logic             stop;
   logic             abort;
   logic             data_out;
   logic             tx_valid;
   logic             busy;
   logic             slos_sent;
   logic             done;
   logic [CNT_W-1:0] sent_count;

   modport master (
      output start, slos_sel, rep_count, stop, abort,
      input  data_out, tx_valid, busy, slos_sent, done, sent_count
   );

   modport slave (
      input  start, slos_sel, rep_count, stop, abort,
      output data_out, tx_valid, busy, slos_sent, done, sent_count
   );
endinterface

// File: rtl/prbs11_lfsr.sv
// PRBS11 register with synchronous reload to the seed and step enable.
module prbs11_lfsr
   import usb4_slos_pkg::*;
#(
   parameter logic [10:0] SEED = PRBS11_SEED
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic        advance,
   output logic [10:0] lfsr
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lfsr <= SEED;
      end else if (load) begin
         lfsr <= SEED;
      end else if (advance) begin
         lfsr <= prbs11_next(lfsr);
      end
   end

endmodule

// File: rtl/prbs11_slos_tx.sv
// SLOS1/SLOS2 serial burst generator: back-to-back full PRBS11 periods,
// optionally inverted, with graceful stop and immediate abort.
//
// state | meaning
// IDLE  | waiting for start; outputs quiet
// SEND  | one SLOS bit per clock, reseeding at each SLOS boundary
// DONE  | single cycle after the last bit; raises done, ignores start
module prbs11_slos_tx
   import usb4_slos_pkg::*;
#(
   parameter logic [10:0] SEED     = PRBS11_SEED,
   parameter int          SLOS_LEN = PRBS11_LEN,
   parameter int          CNT_W    = 8
) (
   input  logic               clk,
   input  logic               reset,
   prbs11_slos_tx_if.slave    bus
);

   localparam int BIT_W = $clog2(SLOS_LEN);

   slos_state_t      state;
   logic [10:0]      lfsr;
   logic [BIT_W-1:0] bit_cnt;
   logic             sel_q;
   logic [CNT_W-1:0] rep_q;
   logic             stop_pend;
   logic             start_ok;
   logic             last_bit;
   logic             burst_end;
   logic [CNT_W-1:0] cnt_inc;

   assign start_ok  = (state == IDLE) && bus.start && !bus.abort;
   assign last_bit  = (state == SEND) && (bit_cnt == BIT_W'(SLOS_LEN - 1));
   assign cnt_inc   = (bus.sent_count == '1) ? bus.sent_count : bus.sent_count + 1'b1;
   assign burst_end = stop_pend || bus.stop || ((rep_q != '0) && (cnt_inc == rep_q));

   // The period equals the sequence length, so the reload at last_bit is
   // redundant in theory but keeps the pattern locked if SLOS_LEN is mis-set.
   prbs11_lfsr #(.SEED(SEED)) u_lfsr (
      .clk     (clk),
      .reset   (reset),
      .load    (bus.abort || start_ok || last_bit),
      .advance (state == SEND),
      .lfsr    (lfsr)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= IDLE;
         bit_cnt        <= '0;
         sel_q          <= 1'b0;
         rep_q          <= '0;
         stop_pend      <= 1'b0;
         bus.data_out   <= 1'b0;
         bus.tx_valid   <= 1'b0;
         bus.busy       <= 1'b0;
         bus.slos_sent  <= 1'b0;
         bus.done       <= 1'b0;
         bus.sent_count <= '0;
      end else if (bus.abort) begin
         state         <= IDLE;
         bit_cnt       <= '0;
         stop_pend     <= 1'b0;
         bus.data_out  <= 1'b0;
         bus.tx_valid  <= 1'b0;
         bus.busy      <= 1'b0;
         bus.slos_sent <= 1'b0;
         bus.done      <= 1'b0;
      end else begin
         bus.data_out  <= 1'b0;
         bus.tx_valid  <= 1'b0;
         bus.slos_sent <= 1'b0;
         bus.done      <= 1'b0;
         case (state)
            IDLE: begin
               bus.busy <= 1'b0;
               if (bus.start) begin
                  sel_q          <= bus.slos_sel;
                  rep_q          <= bus.rep_count;
                  bit_cnt        <= '0;
                  stop_pend      <= 1'b0;
                  bus.sent_count <= '0;
                  bus.busy       <= 1'b1;
                  state          <= SEND;
               end
            end
            SEND: begin
               bus.busy     <= 1'b1;
               bus.data_out <= lfsr[0] ^ sel_q;
               bus.tx_valid <= 1'b1;
               if (last_bit) begin
                  bus.slos_sent  <= 1'b1;
                  bit_cnt        <= '0;
                  bus.sent_count <= cnt_inc;
                  if (burst_end) begin
                     state <= DONE;
                  end
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bus.stop) begin
                     stop_pend <= 1'b1;
                  end
               end
            end
            DONE: begin
               bus.busy <= 1'b1;
               bus.done <= 1'b1;
               state    <= IDLE;
            end
            default: begin
               bus.busy <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_prbs11_slos_tx.sv
// Directed bench for prbs11_slos_tx: golden PRBS11 recurrence feeds an
// expected-bit queue that is drained whenever the DUT shows tx_valid.
module tb_prbs11_slos_tx;

   localparam int LEN   = 2047;
   localparam int CNT_W = 8;

   typedef struct packed {
      logic d;
      logic last;
   } exp_t;

   logic clk;
   logic reset;

   prbs11_slos_tx_if #(.CNT_W(CNT_W)) bus ();

   prbs11_slos_tx #(.CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int    checks = 0;
   int    errors = 0;
   exp_t  exp_q[$];
   bit    gold[0:LEN-1];
   bit    [0:10] first11;
   bit    [0:10] f_exp;
   bit    [0:10] f_exp_inv;
   int    n_valid, n_done, n_sent, max_gap, gap, first_idx;
   int    last_valid_cyc, done_cyc, first_done_cyc;
   logic  busy_at_done;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_data_out"},   bus.data_out,   0);
      chk({tag, "_tx_valid"},   bus.tx_valid,   0);
      chk({tag, "_busy"},       bus.busy,       0);
      chk({tag, "_slos_sent"},  bus.slos_sent,  0);
      chk({tag, "_done"},       bus.done,       0);
      chk({tag, "_sent_count"}, bus.sent_count, 0);
   endtask

   task automatic push_slos(input bit sel, input int n);
      for (int k = 0; k < n; k++)
         for (int i = 0; i < LEN; i++)
            exp_q.push_back('{d: gold[i] ^ sel, last: (i == LEN - 1)});
   endtask

   task automatic launch(input bit sel, input int n);
      @(negedge clk);
      bus.slos_sel  = sel;
      bus.rep_count = CNT_W'(n);
      bus.start     = 1'b1;
   endtask

   // cut_kind: 0 none, 1 abort at cut_at bits, 2 reset at cut_at bits
   task automatic run(input int budget, input int target_done, input int stop_at,
                      input int cut_at, input int cut_kind, input bit hold);
      int   cyc;
      bit   finished;
      bit   stop_fired;
      exp_t e;
      cyc = 0; finished = 0; stop_fired = 0;
      n_valid = 0; n_done = 0; n_sent = 0; max_gap = 0; gap = 0; first_idx = -1;
      last_valid_cyc = -1; done_cyc = -1; first_done_cyc = -1; first11 = '0;
      busy_at_done = 1'bx;
      while (!finished && cyc < budget) begin
         @(negedge clk);
         cyc++;
         if (!hold && bus.start) begin
            bus.start = 1'b0;
            // mid-burst changes must not matter
            bus.slos_sel  = ~bus.slos_sel;
            bus.rep_count = bus.rep_count + CNT_W'(1);
         end
         if (hold && first_done_cyc >= 0 && cyc > first_done_cyc) bus.start = 1'b0;
         if (bus.abort) begin
            bus.abort = 1'b0;
            chk("abort_tx_valid", bus.tx_valid, 0);
            chk("abort_slos_sent", bus.slos_sent, 0);
            chk("abort_done", bus.done, 0);
            finished = 1;
         end else begin
            if (bus.tx_valid) begin
               if (first_idx < 0) first_idx = cyc;
               if (gap > max_gap) max_gap = gap;
               gap = 0;
               last_valid_cyc = cyc;
               if (exp_q.size() == 0) begin
                  chk("unexpected_bit", bus.tx_valid, 0);
               end else begin
                  e = exp_q.pop_front();
                  chk("data_out", bus.data_out, e.d);
                  chk("slos_sent", bus.slos_sent, e.last);
               end
               if (n_valid < 11) first11[n_valid] = bus.data_out;
               n_valid++;
            end else begin
               if (n_valid > 0) gap++;
               chk("slos_sent_idle", bus.slos_sent, 0);
            end
            if (bus.slos_sent) n_sent++;
            if (bus.done) begin
               n_done++;
               done_cyc = cyc;
               busy_at_done = bus.busy;
               if (first_done_cyc < 0) first_done_cyc = cyc;
               if (target_done > 0 && n_done == target_done) finished = 1;
            end
            if (bus.stop) bus.stop = 1'b0;
            else if (!stop_fired && n_valid == stop_at) begin
               bus.stop = 1'b1;
               stop_fired = 1;
            end
            if (cut_kind != 0 && n_valid == cut_at) begin
               if (cut_kind == 1) begin
                  bus.abort = 1'b1;
               end else begin
                  reset = 1'b0;
                  #1;
                  chk_quiet("reset_mid_send");
                  finished = 1;
               end
            end
         end
      end
      chk("run_completed", finished, 1);
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      bus.abort = 1'b0;
   endtask

   initial begin
      bit h[0:LEN+10];
      for (int i = 0; i <= LEN + 10; i++) h[i] = 1'b0;
      // h[k] holds output bit o[k-10]; the seed means o[-10]=1, o[-9..0]=0
      h[0] = 1'b1;
      for (int m = 1; m < LEN; m++) h[m + 10] = h[m - 1] ^ h[m + 1];
      for (int m = 0; m < LEN; m++) gold[m] = h[m + 10];
      f_exp     = 11'b01000000001;
      f_exp_inv = ~f_exp;

      reset         = 1'b0;
      bus.start     = 1'b0;
      bus.slos_sel  = 1'b0;
      bus.rep_count = '0;
      bus.stop      = 1'b0;
      bus.abort     = 1'b0;
      repeat (3) @(negedge clk);
      chk_quiet("reset");
      reset = 1'b1;
      @(negedge clk);

      // reset asserted in the middle of a SLOS, then a fresh burst
      push_slos(1'b0, 1);
      launch(1'b0, 1);
      run(700, 0, -1, 500, 2, 0);
      @(negedge clk);
      reset = 1'b1;
      exp_q.delete();

      // SLOS1, one repetition
      push_slos(1'b0, 1);
      launch(1'b0, 1);
      run(2200, 1, -1, -1, 0, 0);
      chk("s1_first11", first11, f_exp);
      chk("s1_first_latency", first_idx, 2);
      chk("s1_bits", n_valid, LEN);
      chk("s1_slos_sent", n_sent, 1);
      chk("s1_done_count", n_done, 1);
      chk("s1_done_after_last", done_cyc, last_valid_cyc + 1);
      chk("s1_busy_with_done", busy_at_done, 1);
      chk("s1_sent_count", bus.sent_count, 1);
      chk("s1_queue_left", exp_q.size(), 0);
      @(negedge clk);
      chk("s1_busy_after", bus.busy, 0);
      chk("s1_done_after", bus.done, 0);

      // SLOS2, three repetitions back-to-back
      push_slos(1'b1, 3);
      launch(1'b1, 3);
      run(6400, 1, -1, -1, 0, 0);
      chk("s2_first11", first11, f_exp_inv);
      chk("s2_bits", n_valid, 3 * LEN);
      chk("s2_contiguous", max_gap, 0);
      chk("s2_slos_sent", n_sent, 3);
      chk("s2_done_count", n_done, 1);
      chk("s2_sent_count", bus.sent_count, 3);
      chk("s2_queue_left", exp_q.size(), 0);

      // continuous, graceful stop in the middle of the second SLOS
      push_slos(1'b0, 2);
      launch(1'b0, 0);
      run(4400, 1, 3000, -1, 0, 0);
      chk("stop_bits", n_valid, 2 * LEN);
      chk("stop_slos_sent", n_sent, 2);
      chk("stop_done_count", n_done, 1);
      chk("stop_sent_count", bus.sent_count, 2);
      chk("stop_queue_left", exp_q.size(), 0);

      // abort 100 bits into the second SLOS of a five-SLOS burst
      push_slos(1'b0, 5);
      launch(1'b0, 5);
      run(2400, 0, -1, LEN + 100, 1, 0);
      chk("abort_bits", n_valid, LEN + 100);
      chk("abort_no_done", n_done, 0);
      chk("abort_sent_count", bus.sent_count, 1);
      chk("abort_busy", bus.busy, 0);
      n_done = 0;
      repeat (3) begin
         @(negedge clk);
         if (bus.done || bus.tx_valid) n_done++;
      end
      chk("abort_stays_quiet", n_done, 0);
      chk("abort_count_holds", bus.sent_count, 1);
      exp_q.delete();

      // start together with abort is ignored
      @(negedge clk);
      bus.start = 1'b1;
      bus.abort = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      bus.abort = 1'b0;
      chk("start_abort_busy", bus.busy, 0);
      @(negedge clk);
      chk("start_abort_tx_valid", bus.tx_valid, 0);

      // restart after abort begins again at the seed
      push_slos(1'b0, 1);
      launch(1'b0, 1);
      run(2200, 1, -1, -1, 0, 0);
      chk("restart_first11", first11, f_exp);
      chk("restart_bits", n_valid, LEN);
      chk("restart_sent_count", bus.sent_count, 1);

      // start held through DONE: second burst on the following IDLE cycle
      push_slos(1'b0, 2);
      launch(1'b0, 1);
      run(4400, 2, -1, -1, 0, 1);
      chk("hold_bits", n_valid, 2 * LEN);
      chk("hold_gap", max_gap, 2);
      chk("hold_done_count", n_done, 2);
      chk("hold_slos_sent", n_sent, 2);
      chk("hold_sent_count", bus.sent_count, 1);
      chk("hold_queue_left", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
